// File: rtl/systolic_edge_feeder.sv
// systolic_edge_feeder: skews K FP16/INT4 row-vectors onto the west/north edges of an N x N systolic array
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, k_len            begin a transfer of k_len vectors (k_len sampled on start, ignored when busy)
//   in_act, in_wgt          upstream activation/weight vector, lane i at [i*width +: width]
//   in_valid, in_ready      upstream valid/ready handshake (in_ready depends on state only)
//   edge_act, edge_wgt      skewed per-lane edge data, zero on invalid lanes
//   edge_valid              per-lane edge valid, lane i lags lane 0 by i cycles
//   busy, done              not idle / single-cycle pulse once the skew pipeline has drained
module systolic_edge_feeder #(
  parameter int N = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ACTIVATION_WIDTH = 16,
  parameter int KW = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [KW-1:0]                 k_len,
  input  logic [N*ACTIVATION_WIDTH-1:0] in_act,
  input  logic [N*WEIGHT_WIDTH-1:0]     in_wgt,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [N*ACTIVATION_WIDTH-1:0] edge_act,
  output logic [N*WEIGHT_WIDTH-1:0]     edge_wgt,
  output logic [N-1:0]                  edge_valid,
  output logic                          busy,
  output logic                          done
);
  localparam int A = ACTIVATION_WIDTH;
  localparam int W = WEIGHT_WIDTH;
  localparam int EW = A + W + 1;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;
  state_t state;
  logic [KW-1:0] k, cnt;
  logic acc;
  assign in_ready = state == STREAM;
  assign acc = in_valid & in_ready;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // cnt counts accepted beats in STREAM, then is reused to time the N flush cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= k_len == '0 ? DONE : STREAM;
          k <= k_len;
          cnt <= '0;
        end
        STREAM: if (acc) begin
          state <= cnt == k - 1'b1 ? FLUSH : STREAM;
          cnt <= cnt == k - 1'b1 ? '0 : cnt + 1'b1;
        end
        FLUSH: begin
          state <= cnt == KW'(N - 1) ? DONE : FLUSH;
          cnt <= cnt + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // Lane i is i+1 registers deep; the head only carries data on an accepted beat,
  // so bubbles and flush cycles shift in all-zero entries and invalid lanes read zero.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [EW-1:0] sr [0:i];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= i; j++) sr[j] <= '0;
      end else begin
        sr[0] <= acc ? {1'b1, in_act[i*A +: A], in_wgt[i*W +: W]} : '0;
        for (int j = 1; j <= i; j++) sr[j] <= sr[j-1];
      end
    end
    assign {edge_valid[i], edge_act[i*A +: A], edge_wgt[i*W +: W]} = sr[i];
  end
endmodule

// File: tb/tb_systolic_edge_feeder.sv
// tb_systolic_edge_feeder: scoreboard bench for systolic_edge_feeder
module tb_systolic_edge_feeder;
  localparam int N = 4, W = 4, A = 16, KW = 16;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [KW-1:0] k_len = '0;
  logic [N*A-1:0] in_act = '0, edge_act;
  logic [N*W-1:0] in_wgt = '0, edge_wgt;
  logic [N-1:0] edge_valid;
  logic in_ready, busy, done;

  systolic_edge_feeder #(.N(N), .WEIGHT_WIDTH(W), .ACTIVATION_WIDTH(A), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .in_act(in_act), .in_wgt(in_wgt),
    .in_valid(in_valid), .in_ready(in_ready), .edge_act(edge_act), .edge_wgt(edge_wgt),
    .edge_valid(edge_valid), .busy(busy), .done(done));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int due; logic [A-1:0] a; logic [W-1:0] w;} ent_t;
  ent_t lq [N][$];
  int dq[$];
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every beat expected on lane i at cycle due must show up exactly then
  always @(negedge clk) if (rst_n) begin
    for (int i = 0; i < N; i++) begin
      while (lq[i].size() > 0 && lq[i][0].due < cyc) begin
        chk($sformatf("lane%0d_missing", i), cyc, lq[i][0].due);
        void'(lq[i].pop_front());
      end
      if (edge_valid[i]) begin
        if (lq[i].size() == 0) chk($sformatf("lane%0d_unexpected", i), edge_valid[i], 0);
        else begin
          ent_t e;
          e = lq[i].pop_front();
          chk($sformatf("lane%0d_time", i), cyc, e.due);
          chk($sformatf("lane%0d_act", i), edge_act[i*A +: A], e.a);
          chk($sformatf("lane%0d_wgt", i), edge_wgt[i*W +: W], e.w);
        end
      end else begin
        chk($sformatf("lane%0d_act_zero", i), edge_act[i*A +: A], 0);
        chk($sformatf("lane%0d_wgt_zero", i), edge_wgt[i*W +: W], 0);
      end
    end
    while (dq.size() > 0 && dq[0] < cyc) begin
      chk("done_missing", cyc, dq[0]);
      void'(dq.pop_front());
    end
    if (done) begin
      chk("busy_in_done", busy, 1);
      chk("valid_in_done", edge_valid, 0);
      if (dq.size() == 0) chk("done_unexpected", done, 0);
      else chk("done_time", cyc, dq.pop_front());
    end
  end

  // mode: 0 = in_valid always high, 1 = random bubbles, 2 = valid pattern 1,0,0,1
  task automatic xfer(input int k, input int mode, input bit fixed, input int abort_after, input int extra_k);
    logic [A-1:0] ta [3];
    logic [W-1:0] tw [3];
    logic [A-1:0] a;
    logic [W-1:0] w;
    int s, left, j, nacc, last;
    bit v;
    ta[0] = 16'h4000; ta[1] = 16'h3E00; ta[2] = 16'hC400;
    tw[0] = 4'd3; tw[1] = 4'd5; tw[2] = 4'd7;
    @(posedge clk); #1;
    start = 1; k_len = KW'(k); s = cyc + 1;
    @(posedge clk); #1;
    start = 0; k_len = KW'($urandom);
    chk("busy_after_start", busy, 1);
    if (k == 0) begin
      dq.push_back(s);
      chk("ready_k0", in_ready, 0);
      repeat (2) begin @(posedge clk); #1; chk("ready_k0", in_ready, 0); end
      return;
    end
    left = k; j = 0; nacc = 0;
    while (left > 0) begin
      chk("ready_stream", in_ready, 1);
      v = mode == 0 ? 1'b1 : mode == 2 ? (j % 4 == 0 || j % 4 == 3) : 1'($urandom_range(0, 1));
      start = extra_k > 0 && j == 2;
      k_len = KW'(extra_k);
      in_valid = v;
      for (int i = 0; i < N; i++) begin
        a = fixed ? ta[nacc] : A'($urandom);
        w = fixed ? tw[nacc] : W'($urandom);
        in_act[i*A +: A] = a;
        in_wgt[i*W +: W] = w;
        if (v) lq[i].push_back('{cyc + 1 + i, a, w});
      end
      if (v) begin left--; nacc++; end
      @(posedge clk); #1;
      j++;
      if (abort_after > 0 && nacc == abort_after) begin
        rst_n = 0;
        in_valid = 0; start = 0;
        for (int i = 0; i < N; i++) lq[i].delete();
        dq.delete();
        #1;
        chk("rst_edge_valid", edge_valid, 0);
        chk("rst_edge_act", edge_act, 0);
        chk("rst_edge_wgt", edge_wgt, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        repeat (2) begin @(posedge clk); #1; chk("post_rst_ready", in_ready, 0); chk("post_rst_busy", busy, 0); end
        return;
      end
    end
    in_valid = 0; start = 0;
    in_act = {N{16'hFFFF}}; in_wgt = '1;
    last = cyc;
    dq.push_back(last + N);
    while (cyc < last + N + 1) begin
      chk("ready_flush", in_ready, 0);
      @(posedge clk); #1;
    end
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("reset_edge_valid", edge_valid, 0);
    chk("reset_edge_act", edge_act, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    xfer(3, 0, 1, 0, 0);
    xfer(2, 2, 0, 0, 0);
    xfer(0, 0, 0, 0, 0);
    xfer(6, 0, 0, 0, 5);
    xfer(1, 0, 0, 0, 0);
    xfer(8, 0, 0, 3, 0);
    xfer(1, 0, 0, 0, 0);
    repeat (8) xfer($urandom_range(1, 20), 1, 0, 0, 0);
    xfer(65535, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("lane%0d_drained", i), lq[i].size(), 0);
    chk("done_drained", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
